// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one bit per cycle through a 1-bit slice with a registered carry, LSB first.
// Latency WIDTH cycles from accept to out_valid; result held in DONE until out_ready, no accept while busy.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [2:0]       mode_q;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_a, bit_b, f, co;
  logic             last_bit;

  // Subtract modes reuse the adder with one operand inverted at the slice input.
  assign bit_a = a_sr[0] ^ (mode_q == 3'b111);
  assign bit_b = b_sr[0] ^ (mode_q == 3'b110);

  always_comb begin
    f  = 1'b0;
    co = 1'b0;
    case (mode_q)
      3'b000:  f = a_sr[0] & b_sr[0];
      3'b001:  f = a_sr[0] | b_sr[0];
      3'b010:  f = a_sr[0] ^ b_sr[0];
      3'b011:  f = ~(a_sr[0] ^ b_sr[0]);
      3'b100: begin
        f  = a_sr[0] ^ carry;
        co = a_sr[0] & carry;
      end
      default: begin
        f  = bit_a ^ bit_b ^ carry;
        co = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
      end
    endcase
  end

  assign res_nxt  = {f, res_sr[WIDTH-1:1]};
  assign last_bit = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      mode_q    <= '0;
      carry     <= 1'b0;
      count     <= '0;
      result    <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr   <= a;
          b_sr   <= b;
          mode_q <= mode;
          carry  <= cin;
          count  <= '0;
        end
        RUN: begin
          res_sr <= res_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= co;
          if (last_bit) begin
            result    <= res_nxt;
            cout      <= co;
            out_valid <= 1'b1;
            count     <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DONE);
endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer: accepts a full-width operand pair and a 3-bit operation code, then evaluates the result one bit per clock, LSB first, through an internal 1-bit ALU slice with a registered carry. It sits between the execute-stage issue logic and the writeback mux as a low-area alternative to the parallel ALU. It drives operand/carry bits into the slice and reassembles the slice's sum/carry outputs into a parallel result. Both sides use valid/ready handshakes.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; equals (state == IDLE).
- mode  in  3  operation code {M,S1,S0}; sampled on accept.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- cin  in  1  carry into bit 0; sampled on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  parallel result, registered.
- cout  out  1  carry out of bit WIDTH-1, registered.
- busy  out  1  high in RUN or DONE.

## Operation
- Per-bit function, with c = current carry and f/co = bit result/next carry:
  - 000: f = a&b, co = 0.
  - 001: f = a|b, co = 0.
  - 010: f = a^b, co = 0.
  - 011: f = ~(a^b), co = 0.
  - 100 (increment): f = a^c, co = a&c.
  - 101 (add): f = a^b^c, co = majority(a,b,c).
  - 110 (A−B): same as add with b inverted.
  - 111 (B−A): same as add with a inverted.
- cin is used raw; the caller supplies cin = 1 for two's-complement subtract or increment.
- Logic modes force the carry register to 0 from the first bit, so cout = 0 regardless of cin.
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready = 1. When in_valid = 1, capture a and b into shift registers, capture mode, load carry ← cin, count ← 0, and go to RUN.
- RUN, each cycle:
  - Compute f/co from a_sr[0], b_sr[0] and carry.
  - res_sr ← {f, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; carry ← co; count ← count + 1.
  - When count == WIDTH-1 (last bit processed), load result ← final res_sr value and cout ← co, then go to DONE.
- DONE: out_valid = 1; result and cout are held stable. When out_ready = 1, go to IDLE.
- count width: clog2(WIDTH). No wrap beyond WIDTH-1.
- in_valid is ignored outside IDLE. There is no queuing and no accept-while-DONE.
- Reset, in any state including mid-RUN:
  - Next state is IDLE and the operation in flight is discarded.
  - out_valid = 0, result = 0, cout = 0, carry = 0, count = 0.
  - in_ready is 1 from the first cycle after rst deasserts.

## Timing
- Accept edge E0 is the edge where in_valid & in_ready.
- Edges E1..E_WIDTH process bits 0..WIDTH-1.
- out_valid rises after E_WIDTH, so latency is WIDTH cycles from accept to out_valid.
- If out_ready = 1 when out_valid rises, the result is consumed at E_WIDTH+1 and in_ready rises after that edge.
- Minimum initiation interval: WIDTH+2 cycles.
- out_valid, result and cout are registered outputs. in_ready and busy are decoded from the state register only, with no input-to-output combinational paths.
- out_valid stays high until the out_ready handshake edge. A change on out_ready before that edge has no effect.

## Test plan
- WIDTH=8, mode 101, a=0x5A, b=0x3C, cin=0 → result 0x96, cout 0; out_valid first high exactly 8 cycles after accept.
- Subtract (mode 110, cin=1):
  - a=0x10, b=0x01 → 0x0F, cout 1.
  - a=0x01, b=0x02 → 0xFF, cout 0 (borrow).
- Increment and reverse subtract:
  - mode 100, a=0xFF, cin=1 → 0x00, cout 1.
  - mode 111, a=0x03, b=0x05, cin=1 → 0x02, cout 1.
- Logic modes with a=0xF0, b=0xAA, cin=1 → 000: 0xA0, 001: 0xFA, 010: 0x5A, 011: 0xA5; cout 0 in all four.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands → result and cout stable, in_ready 0, no new capture; after out_ready=1 the next request is accepted and correct.
- Reset mid-RUN: assert rst at bit 3 of an add → IDLE on the next cycle, out_valid never asserts for that operation; a fresh request after release completes correctly.
